// File: rtl/pf_iod_eye_train_ctrl_if.sv
// Fabric-to-IOD eye-training pins plus the sequencer start/status handshake for one lane.
// The controller drives the IOD pulses and status; the slave side is the sequencer/IOD pair.
interface pf_iod_eye_train_ctrl_if;
    logic       TRAIN_START;
    logic       EYE_MONITOR_EARLY;
    logic       EYE_MONITOR_LATE;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic [7:0] TAP_POS;
    logic [7:0] WIN_START;
    logic [7:0] WIN_END;
    logic       TRAIN_BUSY;
    logic       TRAIN_DONE;
    logic       TRAIN_ERR;

    modport master (
        input  TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        output EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               TAP_POS, WIN_START, WIN_END, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR
    );

    modport slave (
        output TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        input  EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               TAP_POS, WIN_START, WIN_END, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR
    );
endinterface

// File: rtl/pf_iod_eye_train_ctrl.sv
// Eye-monitor training: scans delay taps for the first passing window, then centres the delay line on it.
// All outputs registered (LOAD the cycle after START, DWELL_CYC+3 cycles per tap); no backpressure, START ignored while busy.
module pf_iod_eye_train_ctrl #(
    parameter int TAP_MAX   = 127,
    parameter int DWELL_CYC = 16,
    parameter int MIN_WIN   = 4
) (
    input logic                    FAB_CLK,
    input logic                    SYNC_RST,
    pf_iod_eye_train_ctrl_if.master io
);
    localparam int              DW         = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [7:0]      TAP_LAST   = 8'(TAP_MAX);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [8:0]      MIN_W      = 9'(MIN_WIN);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_DWELL, S_EVAL, S_STEP, S_RETURN, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    tap_pos, tap_nxt;
    logic [7:0]    win_start, ws_nxt;
    logic [7:0]    win_end, we_nxt;
    logic [7:0]    centre, centre_nxt;
    logic          found, found_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic          fail, active, decide;
    logic [8:0]    width;

    logic load_q, clear_q, move_q, dir_q, busy_q, done_q, err_q;
    logic load_nxt, clear_nxt, move_nxt, dir_nxt, busy_nxt, done_nxt, err_nxt;

    assign fail   = io.EYE_MONITOR_EARLY | io.EYE_MONITOR_LATE;
    assign active = !(state inside {S_IDLE, S_DONE, S_ERR});

    // State, datapath and registered outputs
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state     <= S_IDLE;
            tap_pos   <= '0;
            win_start <= '0;
            win_end   <= '0;
            centre    <= '0;
            found     <= 1'b0;
            dwell_cnt <= '0;
            load_q    <= 1'b0;
            clear_q   <= 1'b0;
            move_q    <= 1'b0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            tap_pos   <= tap_nxt;
            win_start <= ws_nxt;
            win_end   <= we_nxt;
            centre    <= centre_nxt;
            found     <= found_nxt;
            dwell_cnt <= dwell_nxt;
            load_q    <= load_nxt;
            clear_q   <= clear_nxt;
            move_q    <= move_nxt;
            dir_q     <= dir_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tap_nxt    = tap_pos;
        ws_nxt     = win_start;
        we_nxt     = win_end;
        centre_nxt = centre;
        found_nxt  = found;
        dwell_nxt  = dwell_cnt;
        decide     = 1'b0;
        width      = '0;
        if (io.DELAY_LINE_OUT_OF_RANGE && active) begin
            state_nxt = S_ERR;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (io.TRAIN_START) begin
                        state_nxt = S_LOAD;
                        ws_nxt    = '0;
                        we_nxt    = '0;
                        found_nxt = 1'b0;
                    end
                end
                S_LOAD: begin
                    tap_nxt   = '0;
                    state_nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    dwell_nxt = '0;
                    state_nxt = S_DWELL;
                end
                S_DWELL: begin
                    if (dwell_cnt == DWELL_LAST) state_nxt = S_EVAL;
                    else                         dwell_nxt = dwell_cnt + 1'b1;
                end
                S_EVAL: begin
                    if (!fail) begin
                        if (!found) begin
                            found_nxt = 1'b1;
                            ws_nxt    = tap_pos;
                        end
                        if (tap_pos == TAP_LAST) begin
                            we_nxt = TAP_LAST;
                            decide = 1'b1;
                        end else begin
                            state_nxt = S_STEP;
                        end
                    end else if (found) begin
                        we_nxt = tap_pos - 8'd1;
                        decide = 1'b1;
                    end else if (tap_pos == TAP_LAST) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_STEP;
                    end
                    // Window closed this cycle: either reject it or head back to its centre
                    if (decide) begin
                        width = {1'b0, we_nxt} - {1'b0, ws_nxt} + 9'd1;
                        if (width < MIN_W) begin
                            state_nxt = S_ERR;
                        end else begin
                            centre_nxt = 8'(({1'b0, ws_nxt} + {1'b0, we_nxt}) >> 1);
                            state_nxt  = S_RETURN;
                        end
                    end
                end
                S_STEP: begin
                    tap_nxt   = tap_pos + 8'd1;
                    state_nxt = S_CLEAR;
                end
                S_RETURN: begin
                    if (move_q)                tap_nxt   = tap_pos - 8'd1;
                    else if (tap_pos <= centre) state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so every pulse is a clean register output
    always_comb begin
        load_nxt  = (state_nxt == S_LOAD);
        clear_nxt = (state_nxt == S_CLEAR);
        move_nxt  = 1'b0;
        dir_nxt   = 1'b0;
        if (state_nxt == S_STEP) begin
            move_nxt = 1'b1;
            dir_nxt  = 1'b1;
        end else if (state_nxt == S_RETURN && !(state == S_RETURN && move_q)
                     && tap_nxt > centre_nxt) begin
            move_nxt = 1'b1;
        end
        busy_nxt = !(state_nxt inside {S_IDLE, S_DONE, S_ERR});
        done_nxt = (state_nxt == S_DONE);
        err_nxt  = (state_nxt == S_ERR);
    end

    assign io.DELAY_LINE_LOAD         = load_q;
    assign io.EYE_MONITOR_CLEAR_FLAGS = clear_q;
    assign io.DELAY_LINE_MOVE         = move_q;
    assign io.DELAY_LINE_DIRECTION    = dir_q;
    assign io.TAP_POS                 = tap_pos;
    assign io.WIN_START               = win_start;
    assign io.WIN_END                 = win_end;
    assign io.TRAIN_BUSY              = busy_q;
    assign io.TRAIN_DONE              = done_q;
    assign io.TRAIN_ERR               = err_q;
endmodule

// File: tb/tb_pf_iod_eye_train_ctrl.sv
// Bench for the eye-training controller: IOD delay-line/flag model, window reference model and scoreboard.
module tb_pf_iod_eye_train_ctrl;
    localparam int TAP_MAX = 15, DWELL_CYC = 4, MIN_WIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pf_iod_eye_train_ctrl_if io();

    pf_iod_eye_train_ctrl #(.TAP_MAX(TAP_MAX), .DWELL_CYC(DWELL_CYC), .MIN_WIN(MIN_WIN)) dut (
        .FAB_CLK (clk),
        .SYNC_RST(rst),
        .io      (io)
    );

    typedef struct {
        int done, err, ws, we, tap, chk_tap, inc, dec;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0, total_moves = 0, total_clears = 0;
    logic [15:0] pass_mask = '0;
    logic        use_late  = 1'b0;
    logic [7:0]  iod_tap   = '0;
    logic        iod_flag  = 1'b0;

    // IOD: tracks the delay-line tap and raises a sticky flag while sitting on a failing tap
    always @(posedge clk) begin
        if (io.DELAY_LINE_LOAD)      iod_tap <= '0;
        else if (io.DELAY_LINE_MOVE) iod_tap <= io.DELAY_LINE_DIRECTION ? iod_tap + 8'd1 : iod_tap - 8'd1;
        if (io.EYE_MONITOR_CLEAR_FLAGS)   iod_flag <= 1'b0;
        else if (!pass_mask[iod_tap[3:0]]) iod_flag <= 1'b1;
    end
    assign io.EYE_MONITOR_EARLY = iod_flag & ~use_late;
    assign io.EYE_MONITOR_LATE  = iod_flag & use_late;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: walk taps upward, window = first run of passing taps, centre on floor midpoint
    function automatic exp_t model(input logic [15:0] m);
        exp_t e = '{default: 0};
        bit found = 0, decided = 0, stop = 0;
        int pos = 0;
        e.chk_tap = 1;
        for (int t = 0; t <= TAP_MAX; t++) begin
            if (!stop) begin
                pos = t;
                if (m[t] && !found) begin found = 1; e.ws = t; end
                if (found && !m[t]) begin
                    e.we = t - 1; decided = 1; stop = 1;
                end else if (t == TAP_MAX) begin
                    if (found) begin e.we = t; decided = 1; end
                    else e.err = 1;
                    stop = 1;
                end else begin
                    e.inc++;
                end
            end
        end
        if (decided) begin
            if (e.we - e.ws + 1 < MIN_WIN) begin
                e.err = 1;
            end else begin
                e.dec  = pos - (e.ws + e.we) / 2;
                pos    = (e.ws + e.we) / 2;
                e.done = 1;
            end
        end
        e.tap = pos;
        return e;
    endfunction

    initial begin : monitor
        int cyc = 0, inc = 0, dec = 0, load_cyc = 0, last_dec = 0, npulse;
        logic prev_fin = 1'b0, fin;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            npulse = int'(io.DELAY_LINE_LOAD) + int'(io.EYE_MONITOR_CLEAR_FLAGS) + int'(io.DELAY_LINE_MOVE);
            if (npulse != 0) check("pulse_exclusive", npulse, 1);
            if (io.DELAY_LINE_LOAD) begin inc = 0; dec = 0; load_cyc = cyc; end
            if (io.EYE_MONITOR_CLEAR_FLAGS) total_clears++;
            if (io.DELAY_LINE_MOVE) begin
                total_moves++;
                if (io.DELAY_LINE_DIRECTION) begin
                    inc++;
                    if (inc == 1) check("first_step_latency", cyc - load_cyc, 7);
                end else begin
                    dec++;
                    if (dec > 1) check("return_spacing", cyc - last_dec, 2);
                    last_dec = cyc;
                end
            end
            fin = io.TRAIN_DONE | io.TRAIN_ERR;
            if (fin && !prev_fin) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_completion actual=done%0d/err%0d expected=none", io.TRAIN_DONE, io.TRAIN_ERR);
                end else begin
                    e = sb.pop_front();
                    check("train_done", int'(io.TRAIN_DONE), e.done);
                    check("train_err", int'(io.TRAIN_ERR), e.err);
                    check("win_start", int'(io.WIN_START), e.ws);
                    check("win_end", int'(io.WIN_END), e.we);
                    if (e.chk_tap != 0) check("tap_pos", int'(io.TAP_POS), e.tap);
                    check("inc_moves", inc, e.inc);
                    check("dec_moves", dec, e.dec);
                    check("busy_at_end", int'(io.TRAIN_BUSY), 0);
                end
            end
            prev_fin = fin;
        end
    end

    task automatic start_pulse();
        io.TRAIN_START = 1'b1;
        @(negedge clk);
        io.TRAIN_START = 1'b0;
    endtask

    task automatic wait_fin(input string name);
        int n = 0;
        while (!(io.TRAIN_DONE | io.TRAIN_ERR) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%0d cycles expected=completion", name, n);
        end
    endtask

    task automatic run(input logic [15:0] m, input logic late);
        pass_mask = m;
        use_late  = late;
        sb.push_back(model(m));
        start_pulse();
        wait_fin("run");
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pulses"}, int'({io.DELAY_LINE_LOAD, io.EYE_MONITOR_CLEAR_FLAGS, io.DELAY_LINE_MOVE, io.DELAY_LINE_DIRECTION}), 0);
        check({name, "_status"}, int'({io.TRAIN_BUSY, io.TRAIN_DONE, io.TRAIN_ERR}), 0);
        check({name, "_tap"}, int'(io.TAP_POS), 0);
        check({name, "_win"}, int'({io.WIN_START, io.WIN_END}), 0);
    endtask

    initial begin : main
        exp_t e;
        int n, k, mv0, cl0, lo, len;
        logic [15:0] m;
        io.TRAIN_START = 1'b0;
        io.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run(16'h03F0, 1'b0);   // window 4..9, fail at 10
        run(16'h0000, 1'b0);   // nothing passes
        run(16'hF000, 1'b0);   // window runs into the top tap
        run(16'h0020, 1'b0);   // one-tap window, too narrow

        // Range error during the third increment step
        pass_mask = 16'h03F0;
        e = '{done: 0, err: 1, ws: 0, we: 0, tap: 0, chk_tap: 0, inc: 3, dec: 0};
        sb.push_back(e);
        start_pulse();
        n = 0; k = 0;
        while (k < 3 && n < 500) begin
            @(negedge clk);
            n++;
            if (io.DELAY_LINE_MOVE) k++;
        end
        check("oor_third_step_seen", k, 3);
        io.DELAY_LINE_OUT_OF_RANGE = 1'b1;
        @(negedge clk);
        io.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        check("oor_err_next_cycle", int'(io.TRAIN_ERR), 1);
        mv0 = total_moves; cl0 = total_clears;
        repeat (20) @(negedge clk);
        check("oor_no_move_after", total_moves - mv0, 0);
        check("oor_no_clear_after", total_clears - cl0, 0);

        // Reset while dwelling on tap 7, then a clean rerun with a stray start mid-scan
        pass_mask = 16'h03F0;
        start_pulse();
        n = 0;
        while (!(io.EYE_MONITOR_CLEAR_FLAGS && io.TAP_POS == 8'd7) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_tap7_clear", int'(io.TAP_POS), 7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        sb.push_back(model(16'h03F0));
        start_pulse();
        repeat (30) @(negedge clk);
        start_pulse();
        check("busy_start_no_load", int'(io.DELAY_LINE_LOAD), 0);
        check("busy_start_still_busy", int'(io.TRAIN_BUSY), 1);
        wait_fin("rerun");
        repeat (3) @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                m = 16'($urandom);
            end else begin
                lo  = $urandom_range(0, 15);
                len = $urandom_range(1, 6);
                m   = '0;
                for (int b = 0; b < 16; b++) if (b >= lo && b < lo + len) m[b] = 1'b1;
            end
            run(m, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=%0t expected=finish_before_limit", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
